// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, default frame geometry and the
// clock/baud constants shared with baud_gen and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;
  localparam int CLK_HZ          = 50_000_000;
  localparam int BAUD            = 115_200;
  localparam int BAUD_DIV        = CLK_HZ / (BAUD * UART_OVERSAMPLE);

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous input; RESET_VAL sets
// the value both stages take during reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // NOTE: non-blocking assignments keep the two stages as distinct flops; a
  // blocking chain here would collapse them into a single register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver with a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bclk,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 overrun
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  rx_state_e            state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;
  logic                 overrun_q;
  logic                 rx_prev_q;
  logic                 rx_s;
  logic                 stop_ok;

  sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bad_q;
  logic parity_err_q;
  assign stop_ok    = rx_s & ~par_bad_q;
  assign parity_err = parity_err_q;
`else
  assign stop_ok    = rx_s;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      rx_prev_q    <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      // A load in the STOP branch below overrides this clear in the same cycle.
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;

      if (bclk) begin
        rx_prev_q <= rx_s;
        case (state_q)
          ST_IDLE: begin
            if (rx_prev_q && !rx_s) begin
              state_q <= ST_START;
              cnt_q   <= '0;
            end
          end
          ST_START: begin
            if (cnt_q == CNT_HALF) begin
              cnt_q     <= '0;
              bit_idx_q <= '0;
              state_q   <= rx_s ? ST_IDLE : ST_DATA;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ST_DATA: begin
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
              if (bit_idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                state_q <= ST_PARITY;
`else
                state_q <= ST_STOP;
`endif
              end else begin
                bit_idx_q <= bit_idx_q + 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          ST_PARITY: begin
            if (cnt_q == CNT_LAST) begin
              cnt_q     <= '0;
              par_bad_q <= (^shift_q) ^ rx_s;
              state_q   <= ST_STOP;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
`endif
          ST_STOP: begin
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              state_q <= ST_IDLE;
              if (!rx_s) frame_err_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
              if (par_bad_q) parity_err_q <= 1'b1;
`endif
              if (stop_ok) begin
                if (!rx_valid_q || rx_ready) begin
                  rx_data_q  <= shift_q;
                  rx_valid_q <= 1'b1;
                end else begin
                  overrun_q <= 1'b1;
                end
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Oversampling UART receiver for the loopback UART datapath, the receive-side counterpart to the transmitter. It consumes the single-cycle 16x-baud enable tick from `baud_gen` and samples the asynchronous serial input at bit centres. It reassembles 8N1 frames, LSB first, into a one-entry holding register with a valid/ready handshake and reports framing and overrun errors. In the loopback top, its output feeds the transmitter's byte input.

## Interface
Parameters:
- `DATA_BITS`, 8: data bits per frame (5–8).
- `OVERSAMPLE`, 16: ticks per bit. Must be even and ≥ 8.

Ports:
- `clk`  in  1  system clock (50 MHz in the loopback top).
- `rst`  in  1  asynchronous, active-high reset.
- `bclk`  in  1  oversample enable: 1-`clk` pulse at OVERSAMPLE × baud, synchronous to `clk`.
- `rx`  in  1  serial line; asynchronous, idles high.
- `rx_data`  out  DATA_BITS  received byte; valid while `rx_valid`=1.
- `rx_valid`  out  1  holding register full.
- `rx_ready`  in  1  consumer accepts; transfer occurs on `rx_valid & rx_ready`.
- `frame_err`  out  1  1-cycle pulse when the stop bit samples 0.
- `overrun`  out  1  1-cycle pulse when a good frame completes while the register is full and `rx_ready`=0.

## Operation
- `rx` passes through a 2-FF synchronizer (reset value 1), then a 1-FF `rx_prev` register updated only on `bclk`.
- All state and counter advances happen only on cycles with `bclk`=1. Tick counter `cnt` has width clog2(OVERSAMPLE); bit counter `bit_idx` has width clog2(DATA_BITS).
- FSM states:
  - IDLE: on a tick with `rx_prev`=1 and synced rx=0 (falling edge) → START, `cnt`=0. A line held low does not retrigger.
  - START: `cnt`++. At `cnt`=OVERSAMPLE/2−1, if rx=0 → DATA with `cnt`=0 and `bit_idx`=0. If rx=1 (glitch) → IDLE with no outputs.
  - DATA: at `cnt`=OVERSAMPLE−1, shift rx into the MSB of the shift register (right shift, so LSB first) and wrap `cnt`. After bit DATA_BITS−1 → STOP (→ PARITY when configured).
  - STOP: at `cnt`=OVERSAMPLE−1, sample rx, then → IDLE in all cases. Outcomes:
    - rx=1, register empty: load `rx_data` and set `rx_valid`.
    - rx=1, `rx_valid`=1 and `rx_ready`=1 in the same cycle: load the new byte; `rx_valid` stays 1.
    - rx=1, `rx_valid`=1 and `rx_ready`=0: drop the new byte; pulse `overrun`.
    - rx=0: discard the byte; pulse `frame_err`.
- `rx_valid` clears on the handshake unless a load happens in that same cycle. `rx_data` is stable while `rx_valid`=1.
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0, FSM=IDLE, counters=0. Reset mid-frame abandons the frame. The next detection requires a falling edge after reset.

## Timing
- Bit sampled at tick OVERSAMPLE/2−1 after the start edge + k×OVERSAMPLE ticks (bit centre), k = 1…DATA_BITS+1.
- Edge-to-detection latency: 2 `clk` (synchronizer) plus up to one tick period.
- `rx_valid`, `frame_err` and `overrun` assert on the `clk` edge following the stop-sample tick cycle (registered outputs; no combinational input→output paths).
- `rx_ready` may be held high permanently. `rx_valid` then pulses for 1 cycle per byte.

## Configuration
- `UART_RX_PARITY_EN`: when defined, adds a PARITY state between DATA and STOP. The parity bit is sampled at the bit centre; even parity is required (XOR of data and parity = 0). Adds output `parity_err` (out, 1, a 1-cycle pulse at the stop-sample edge). A parity-failed frame is discarded like a framing error and pulses `parity_err` instead of loading. When the frame has both a parity failure and a bad stop bit, both flags pulse.
- When undefined: no PARITY state, no `parity_err` port; frame is 1 + DATA_BITS + 1 bits.

## Structure
- Shared package `uart_pkg`: FSM state encoding (IDLE, START, DATA, PARITY, STOP), default OVERSAMPLE=16 and DATA_BITS=8, and a CLK_HZ/BAUD constant shared with `baud_gen` and the transmitter.
- One sub-module: `sync_2ff` (generic 2-FF synchronizer with a reset value parameter), reused for any async input in the top.

## Test plan
Bench: 20 ns clock; `bclk` every 4 clocks (bit = 64 clocks); `rx_ready`=1 unless stated.
- Send 0xA5 8N1 → `rx_data`=0xA5 and `rx_valid` pulses once, ~10 bit times after the start edge; `frame_err`=0.
- Send 0x00 then 0xFF back-to-back with zero idle gap → two valid beats, 0x00 then 0xFF.
- 3-tick low glitch on idle line → no `rx_valid`, FSM returns to IDLE, no error pulses.
- Send 0x3C with stop bit forced 0, hold `rx` low for 2 bit times, then release → one `frame_err` pulse, no `rx_valid`, no retrigger until `rx` goes high and falls again.
- `rx_ready`=0; send 0x11 then 0x22 → `rx_data` stays 0x11, one `overrun` pulse; raise `rx_ready` → 0x11 accepted, `rx_valid`=0.
- Assert `rst` during bit 4 of 0x5A, release, then send 0xC3 → only 0xC3 received. With `UART_RX_PARITY_EN`, send 0x07 with parity 0 → `parity_err` pulse, no `rx_valid`.
